// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one fixed-latency memory port between two requesters.
// Port 0 carries CPU fetch/operand traffic; port 1 carries loader/debug traffic.
module mem_port_arbiter #(
   parameter int unsigned ADDR_W  = 12,
   parameter int unsigned DATA_W  = 8,
   parameter int unsigned MEM_LAT = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0,
   input  logic              we0,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [DATA_W-1:0] wdata0,
   output logic              done0,
   input  logic              req1,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata1,
   output logic              done1,
   output logic [DATA_W-1:0] rdata,
   output logic              busy,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_read,
   output logic              mem_write,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam int unsigned CNT_W = $clog2(MEM_LAT + 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MEM_LAT - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

   state_t           state;
   logic             op;
   logic             gnt_id;
   logic             last_gnt;
   logic [CNT_W-1:0] lat_cnt;
   logic             pick_c;
   logic             pick_we_c;

   // Winner among current requesters: a lone requester wins, a tie goes to the port not served last.
   always_comb begin
      pick_c = 1'b0;
      if (req0 && req1) begin
         pick_c = ~last_gnt;
      end else if (req1) begin
         pick_c = 1'b1;
      end
      pick_we_c = pick_c ? we1 : we0;
   end

   // Access sequencer: grant in IDLE, hold strobes for MEM_LAT cycles, pulse done for one cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         op        <= 1'b0;
         gnt_id    <= 1'b0;
         last_gnt  <= 1'b1;
         lat_cnt   <= '0;
         done0     <= 1'b0;
         done1     <= 1'b0;
         busy      <= 1'b0;
         rdata     <= '0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_read  <= 1'b0;
         mem_write <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req0 || req1) begin
                  gnt_id    <= pick_c;
                  last_gnt  <= pick_c;
                  op        <= pick_we_c;
                  mem_addr  <= pick_c ? addr1 : addr0;
                  mem_wdata <= pick_c ? wdata1 : wdata0;
                  mem_read  <= ~pick_we_c;
                  mem_write <= pick_we_c;
                  lat_cnt   <= '0;
                  busy      <= 1'b1;
                  state     <= ACCESS;
               end
            end
            ACCESS: begin
               if (lat_cnt == LAST_CNT) begin
                  if (!op) begin
                     rdata <= mem_rdata;
                  end
                  mem_read  <= 1'b0;
                  mem_write <= 1'b0;
                  done0     <= ~gnt_id;
                  done1     <= gnt_id;
                  state     <= DONE;
               end else begin
                  lat_cnt <= lat_cnt + CNT_W'(1);
               end
            end
            DONE: begin
               done0 <= 1'b0;
               done1 <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance with MEM_LAT=1 (a), one with MEM_LAT=3 (b).
module tb_mem_port_arbiter;

   localparam int unsigned ADDR_W = 12;
   localparam int unsigned DATA_W = 8;

   logic clk;
   logic rst;

   logic              req0_a, we0_a, req1_a, we1_a;
   logic [ADDR_W-1:0] addr0_a, addr1_a;
   logic [DATA_W-1:0] wdata0_a, wdata1_a, mem_rdata_a;
   logic              done0_a, done1_a, busy_a, mem_read_a, mem_write_a;
   logic [DATA_W-1:0] rdata_a, mem_wdata_a;
   logic [ADDR_W-1:0] mem_addr_a;

   logic              req0_b, we0_b, req1_b, we1_b;
   logic [ADDR_W-1:0] addr0_b, addr1_b;
   logic [DATA_W-1:0] wdata0_b, wdata1_b, mem_rdata_b;
   logic              done0_b, done1_b, busy_b, mem_read_b, mem_write_b;
   logic [DATA_W-1:0] rdata_b, mem_wdata_b;
   logic [ADDR_W-1:0] mem_addr_b;

   int checks;
   int failures;

   mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(1)) u_a (
      .clk(clk), .rst(rst),
      .req0(req0_a), .we0(we0_a), .addr0(addr0_a), .wdata0(wdata0_a), .done0(done0_a),
      .req1(req1_a), .we1(we1_a), .addr1(addr1_a), .wdata1(wdata1_a), .done1(done1_a),
      .rdata(rdata_a), .busy(busy_a), .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a),
      .mem_read(mem_read_a), .mem_write(mem_write_a), .mem_rdata(mem_rdata_a)
   );

   mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(3)) u_b (
      .clk(clk), .rst(rst),
      .req0(req0_b), .we0(we0_b), .addr0(addr0_b), .wdata0(wdata0_b), .done0(done0_b),
      .req1(req1_b), .we1(we1_b), .addr1(addr1_b), .wdata1(wdata1_b), .done1(done1_b),
      .rdata(rdata_b), .busy(busy_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b),
      .mem_read(mem_read_b), .mem_write(mem_write_b), .mem_rdata(mem_rdata_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one rising edge and settle before driving or sampling.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst = 1'b1;
      req0_a = 0; we0_a = 0; addr0_a = '0; wdata0_a = '0;
      req1_a = 0; we1_a = 0; addr1_a = '0; wdata1_a = '0; mem_rdata_a = '0;
      req0_b = 0; we0_b = 0; addr0_b = '0; wdata0_b = '0;
      req1_b = 0; we1_b = 0; addr1_b = '0; wdata1_b = '0; mem_rdata_b = '0;

      // Reset state
      step(); step();
      chk("rst_done0_a", done0_a, 0);
      chk("rst_done1_a", done1_a, 0);
      chk("rst_busy_a", busy_a, 0);
      chk("rst_mem_read_a", mem_read_a, 0);
      chk("rst_mem_write_a", mem_write_a, 0);
      chk("rst_mem_addr_a", mem_addr_a, 0);
      chk("rst_mem_wdata_a", mem_wdata_a, 0);
      chk("rst_rdata_a", rdata_a, 0);
      chk("rst_busy_b", busy_b, 0);
      chk("rst_mem_read_b", mem_read_b, 0);
      rst = 1'b0;
      step();
      chk("idle_busy_a", busy_a, 0);

      // Port 0 read, MEM_LAT=1
      req0_a = 1; we0_a = 0; addr0_a = 12'h005; mem_rdata_a = 8'hA7;
      step();
      chk("t1_mem_read", mem_read_a, 1);
      chk("t1_mem_write", mem_write_a, 0);
      chk("t1_mem_addr", mem_addr_a, 12'h005);
      chk("t1_busy", busy_a, 1);
      chk("t1_done0_early", done0_a, 0);
      step();
      chk("t1_done0", done0_a, 1);
      chk("t1_done1", done1_a, 0);
      chk("t1_mem_read_off", mem_read_a, 0);
      chk("t1_rdata", rdata_a, 8'hA7);
      chk("t1_busy_done", busy_a, 1);
      req0_a = 0;
      step();
      chk("t1_done0_pulse", done0_a, 0);
      chk("t1_busy_idle", busy_a, 0);

      // Port 1 write leaves rdata alone
      req1_a = 1; we1_a = 1; addr1_a = 12'h010; wdata1_a = 8'h3C; mem_rdata_a = 8'h55;
      step();
      chk("t2_mem_write", mem_write_a, 1);
      chk("t2_mem_read", mem_read_a, 0);
      chk("t2_mem_addr", mem_addr_a, 12'h010);
      chk("t2_mem_wdata", mem_wdata_a, 8'h3C);
      step();
      chk("t2_done1", done1_a, 1);
      chk("t2_done0", done0_a, 0);
      chk("t2_mem_write_off", mem_write_a, 0);
      chk("t2_rdata_held", rdata_a, 8'hA7);
      req1_a = 0; we1_a = 0;
      step();
      chk("t2_done1_pulse", done1_a, 0);

      // Both requesting continuously: last grant was port 1, so 0,1,0,1
      req0_a = 1; we0_a = 0; addr0_a = 12'h100;
      req1_a = 1; we1_a = 0; addr1_a = 12'h200;
      mem_rdata_a = 8'h11;
      for (int g = 0; g < 4; g++) begin
         step();
         chk($sformatf("t3_addr_g%0d", g), mem_addr_a, (g % 2 == 0) ? 12'h100 : 12'h200);
         chk($sformatf("t3_read_g%0d", g), mem_read_a, 1);
         step();
         chk($sformatf("t3_done0_g%0d", g), done0_a, (g % 2 == 0) ? 1 : 0);
         chk($sformatf("t3_done1_g%0d", g), done1_a, (g % 2 == 0) ? 0 : 1);
         if (g == 3) begin
            req0_a = 0; req1_a = 0;
         end
         step();
         chk($sformatf("t3_idle_busy_g%0d", g), busy_a, 0);
         chk($sformatf("t3_idle_read_g%0d", g), mem_read_a, 0);
      end
      step();
      chk("t3_no_regrant", busy_a, 0);

      // MEM_LAT=3 read; request dropped and inputs changed during the access
      req0_b = 1; we0_b = 0; addr0_b = 12'h0AB; wdata0_b = 8'h12; mem_rdata_b = 8'h5E;
      step();
      chk("t4_read_c1", mem_read_b, 1);
      chk("t4_addr_c1", mem_addr_b, 12'h0AB);
      req0_b = 0; addr0_b = 12'hFFF; wdata0_b = 8'h99;
      step();
      chk("t4_read_c2", mem_read_b, 1);
      chk("t4_addr_c2", mem_addr_b, 12'h0AB);
      chk("t4_wdata_c2", mem_wdata_b, 8'h12);
      step();
      chk("t4_read_c3", mem_read_b, 1);
      chk("t4_addr_c3", mem_addr_b, 12'h0AB);
      chk("t4_done_early", done0_b, 0);
      step();
      chk("t4_done0", done0_b, 1);
      chk("t4_read_off", mem_read_b, 0);
      chk("t4_rdata", rdata_b, 8'h5E);
      chk("t4_addr_done", mem_addr_b, 12'h0AB);
      step();
      chk("t4_done0_pulse", done0_b, 0);
      chk("t4_busy_idle", busy_b, 0);
      step();
      chk("t4_no_regrant", mem_read_b, 0);

      // MEM_LAT=3 write; write data and address held while inputs move
      req1_b = 1; we1_b = 1; addr1_b = 12'h321; wdata1_b = 8'h42;
      step();
      chk("t6_write_c1", mem_write_b, 1);
      addr1_b = 12'h000; wdata1_b = 8'hEE;
      step();
      chk("t6_wdata_c2", mem_wdata_b, 8'h42);
      chk("t6_addr_c2", mem_addr_b, 12'h321);
      step();
      chk("t6_write_c3", mem_write_b, 1);
      chk("t6_read_c3", mem_read_b, 0);
      step();
      chk("t6_done1", done1_b, 1);
      chk("t6_rdata_held", rdata_b, 8'h5E);
      req1_b = 0; we1_b = 0;
      step();
      chk("t6_done1_pulse", done1_b, 0);

      // Reset during ACCESS, then a tie goes to port 0
      req0_a = 1; we0_a = 0; addr0_a = 12'h077;
      step();
      chk("t5_read_pre", mem_read_a, 1);
      rst = 1; req1_a = 1; we1_a = 1; addr1_a = 12'h0EE; wdata1_a = 8'hC3;
      addr0_a = 12'h0DD;
      step();
      chk("t5_read_rst", mem_read_a, 0);
      chk("t5_write_rst", mem_write_a, 0);
      chk("t5_busy_rst", busy_a, 0);
      chk("t5_done0_rst", done0_a, 0);
      chk("t5_done1_rst", done1_a, 0);
      rst = 0;
      step();
      chk("t5_grant_addr", mem_addr_a, 12'h0DD);
      chk("t5_grant_read", mem_read_a, 1);
      chk("t5_grant_write", mem_write_a, 0);
      step();
      chk("t5_done0", done0_a, 1);
      chk("t5_done1", done1_a, 0);
      req0_a = 0;
      step();
      step();
      chk("t5_second_addr", mem_addr_a, 12'h0EE);
      chk("t5_second_write", mem_write_a, 1);
      chk("t5_second_wdata", mem_wdata_a, 8'hC3);
      req1_a = 0;
      step();
      chk("t5_second_done1", done1_a, 1);
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
